// File: rtl/dbus_ctrl_if.sv
// rtl/dbus_ctrl_if.sv - data-bus req/gnt/rvalid channel between dbus_ctrl and its slave
interface dbus_ctrl_if;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );
endinterface

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - MEM-stage data-bus master: single-cycle access to req/gnt/rvalid with stall and timeout
module dbus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_ce_i,
    input  logic            mem_we_i,
    input  logic [31:0]     mem_addr_i,
    input  logic [3:0]      mem_sel_i,
    input  logic [31:0]     mem_data_i,
    output logic [31:0]     mem_data_o,
    input  logic            stall_i,
    output logic            stallreq_o,
    output logic            err_o,
    dbus_ctrl_if.master     dbus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       timeout_hit;
    logic       abort;
    logic       rd_capture;

    // >= rather than == so a grant on the last REQ cycle still times out in WAIT
    assign timeout_hit = (cnt >= 8'(TIMEOUT - 1));

    assign abort = ((state == REQ)  && !dbus.dbus_gnt_i    && timeout_hit) ||
                   ((state == WAIT) && !dbus.dbus_rvalid_i && timeout_hit);

    assign rd_capture = ((state == REQ) && dbus.dbus_gnt_i && !dbus.dbus_we_o && dbus.dbus_rvalid_i) ||
                        ((state == WAIT) && dbus.dbus_rvalid_i);

    assign stallreq_o = rst && ((state == REQ) || (state == WAIT) || ((state == IDLE) && mem_ce_i));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mem_ce_i) state_nxt = REQ;
            REQ: begin
                if (dbus.dbus_gnt_i) begin
                    if (dbus.dbus_we_o || dbus.dbus_rvalid_i) state_nxt = DONE;
                    else                                      state_nxt = WAIT;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            WAIT: if (dbus.dbus_rvalid_i || timeout_hit) state_nxt = DONE;
            DONE: if (!stall_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dbus.dbus_req_o   <= 1'b0;
            dbus.dbus_we_o    <= 1'b0;
            dbus.dbus_addr_o  <= 32'h0;
            dbus.dbus_sel_o   <= 4'h0;
            dbus.dbus_wdata_o <= 32'h0;
            mem_data_o        <= 32'h0;
            err_o             <= 1'b0;
            cnt               <= 8'h0;
        end else begin
            err_o <= abort;
            if ((state == IDLE) && mem_ce_i) begin
                dbus.dbus_req_o   <= 1'b1;
                dbus.dbus_we_o    <= mem_we_i;
                dbus.dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                dbus.dbus_sel_o   <= mem_sel_i;
                dbus.dbus_wdata_o <= mem_data_i;
                cnt               <= 8'h0;
            end
            if ((state == REQ) || (state == WAIT)) cnt <= cnt + 8'd1;
            if ((state == REQ) && (dbus.dbus_gnt_i || abort)) dbus.dbus_req_o <= 1'b0;
            if (rd_capture)  mem_data_o <= dbus.dbus_rdata_i;
            else if (abort)  mem_data_o <= 32'h0;
        end
    end

endmodule
